periph_reg_fabric: RTL
======================

// Module: periph_reg_fabric
// PURPOSE
//  Parametrised register-bus fabric that sits between the peripheral register port and NUM_SLV
//  peripheral cores (UARTs, I2C, USB host/device, SPI, ...).
//  Decodes the upper address bits to select one slave and forwards a registered request to it.
//  Returns the slave's data and ack to the master.
//  Adds a bus timeout and an error response for unmapped selects.
// PARAMETERS
//  NUM_SLV   8             number of slave ports (1..2**SEL_W)
//  AW        9             master address width (byte address)
//  SEL_W     3             slave select = reg_addr[AW-1 -: SEL_W]
//  DW        32            data width (DW/8 byte enables)
//  TO_W      8             timeout counter width
//  TIMEOUT   200           cycles in BUSY before forced error response (1..2**TO_W-1)
//  ERR_DATA  32'hDEAD_C0DE reg_rdata returned on any error response
// PORTS
//  app_clk    in   1              single clock, all logic rising-edge
//  sreset     in   1              synchronous reset, active high
//  reg_cs     in   1              master request; held with addr/wr/wdata/be until reg_ack
//  reg_wr     in   1              1 = write, 0 = read
//  reg_addr   in   AW             byte address
//  reg_wdata  in   DW             write data
//  reg_be     in   DW/8           byte enables
//  reg_rdata  out  DW             read data, valid only with reg_ack
//  reg_ack    out  1              one-cycle completion pulse
//  reg_err    out  1              qualifies reg_ack: timeout or unmapped select
//  slv_cs     out  NUM_SLV        one-hot slave request, registered
//  slv_wr     out  1              captured reg_wr (shared by all slaves)
//  slv_addr   out  AW-SEL_W       captured offset reg_addr[AW-SEL_W-1:0]
//  slv_wdata  out  DW             captured write data
//  slv_be     out  DW/8           captured byte enables
//  slv_rdata  in   NUM_SLV*DW     slave i data on [i*DW +: DW]
//  slv_ack    in   NUM_SLV        slave one-cycle ack
//  err_cnt    out  8              error counter (see CONFIGURATION)
//  err_addr   out  AW             last error address (see CONFIGURATION)
// BEHAVIOUR
//  Reset values
//   - All registered outputs are 0; FSM goes to IDLE.
//   - reg_rdata resets to 0, not ERR_DATA.
//  FSM states: IDLE, BUSY, RESP, GAP.
//   - IDLE: on reg_cs=1, capture wr/addr/wdata/be and sel.
//     - sel < NUM_SLV: set slv_cs[sel]=1, clear timeout count, go to BUSY.
//     - sel >= NUM_SLV: go to RESP with err=1; no slave is touched.
//   - BUSY: while slv_cs[sel] is high, count cycles.
//     - slv_ack[sel]=1: capture slv_rdata[sel], clear slv_cs, go to RESP with err=0.
//     - Otherwise, when count==TIMEOUT-1: clear slv_cs, go to RESP with err=1.
//     - slv_ack[sel] and timeout in the same cycle: the ack wins (no error).
//   - RESP: reg_ack=1 for exactly one cycle.
//     - reg_rdata = captured data, or ERR_DATA on error; reg_err = err.
//     - Write acks also drive reg_rdata.
//   - GAP: one idle cycle so the master's held reg_cs is not taken as a new request; then IDLE.
//  Ack rules
//   - slv_ack from a non-selected slave, or any slv_ack outside BUSY, is ignored.
//   - A late ack after a timeout is dropped.
//  Latency
//   - reg_cs sampled at edge 0 -> slv_cs high after edge 0.
//   - Slave acks at edge k -> reg_ack high after edge k+1.
//   - Back-to-back minimum is 4 cycles per transfer with a 1-cycle slave.
//   - Unmapped select: reg_ack high after edge 1.
//  Stability: slv_* outputs are stable for the whole time slv_cs is high.
//  Reset mid-transfer
//   - slv_cs drops; no reg_ack is issued; the master must reissue.
//   - A dropped reg_cs mid-BUSY is protocol violation; the transfer still completes.
// CONFIGURATION
//  PERIPH_FABRIC_ERR_LOG_EN defined:
//   - Every error response increments err_cnt, saturating at 8'hFF.
//   - The same response loads err_addr with the full reg_addr.
//   - Both clear only on sreset.
//  PERIPH_FABRIC_ERR_LOG_EN undefined: err_cnt and err_addr are tied to 0 (no flops).
// TESTING
//  1. Read, slave 2 (addr 9'h080), slave acks 1 cycle after cs with 32'h1234_5678:
//     slv_cs=8'h04 for 2 cycles; reg_ack 1 cycle later with rdata 32'h1234_5678, reg_err=0.
//  2. Write addr 9'h0C4, wdata 32'hA5A5_A5A5, be=4'h3, slave 3 acks:
//     slv_addr=6'h04, slv_wdata and slv_be stable while slv_cs=8'h08; single reg_ack.
//  3. NUM_SLV=6, reg_addr=9'h1C0 (sel 7):
//     no slv_cs; reg_ack after edge 1 with ERR_DATA, reg_err=1; err_cnt=1, err_addr=9'h1C0 (macro on).
//  4. Slave 0 never acks, TIMEOUT=200: slv_cs drops after 200 cycles; reg_ack with reg_err=1.
//     A slave ack 3 cycles later is ignored.
//  5. Slave acks exactly at the timeout cycle: reg_err=0 and rdata is the slave data.
//     Acks from non-selected slaves during BUSY are ignored.
//  6. sreset asserted mid-BUSY: next cycle slv_cs=0, FSM in IDLE, no reg_ack.
//     A new request completes normally; macro off: err_cnt and err_addr read 0 throughout.

Source files
------------

// File: rtl/periph_reg_fabric_if.sv
// periph_reg_fabric_if: master-side register bus between the register port and the fabric.
// Signals: reg_cs/reg_wr/reg_addr/reg_wdata/reg_be (request, held until reg_ack),
//          reg_rdata/reg_ack/reg_err (one-cycle response).
// Modports: master drives the request, slave (the fabric) drives the response.
interface periph_reg_fabric_if #(
    parameter int AW = 9,
    parameter int DW = 32
) ();
    logic            reg_cs;
    logic            reg_wr;
    logic [AW-1:0]   reg_addr;
    logic [DW-1:0]   reg_wdata;
    logic [DW/8-1:0] reg_be;
    logic [DW-1:0]   reg_rdata;
    logic            reg_ack;
    logic            reg_err;

    modport master (
        output reg_cs, reg_wr, reg_addr, reg_wdata, reg_be,
        input  reg_rdata, reg_ack, reg_err
    );

    modport slave (
        input  reg_cs, reg_wr, reg_addr, reg_wdata, reg_be,
        output reg_rdata, reg_ack, reg_err
    );
endinterface

// File: rtl/periph_reg_fabric.sv
// periph_reg_fabric: decodes reg_addr upper bits to one of NUM_SLV peripheral slaves,
// forwards a registered request, returns data/ack, with bus timeout and unmapped-select error.
// Ports: app_clk, sreset (sync, active high); bus (periph_reg_fabric_if.slave, master register port);
//        slv_cs/slv_wr/slv_addr/slv_wdata/slv_be (registered slave request);
//        slv_rdata/slv_ack (slave response); err_cnt/err_addr (error log).
// Option: define PERIPH_FABRIC_ERR_LOG_EN to keep the error counter and last error address;
//         otherwise err_cnt/err_addr are tied to 0.
module periph_reg_fabric #(
    parameter int              NUM_SLV  = 8,
    parameter int              AW       = 9,
    parameter int              SEL_W    = 3,
    parameter int              DW       = 32,
    parameter int              TO_W     = 8,
    parameter int              TIMEOUT  = 200,
    parameter logic [DW-1:0]   ERR_DATA = 32'hDEAD_C0DE
) (
    input  logic                  app_clk,
    input  logic                  sreset,
    periph_reg_fabric_if.slave    bus,
    output logic [NUM_SLV-1:0]    slv_cs,
    output logic                  slv_wr,
    output logic [AW-SEL_W-1:0]   slv_addr,
    output logic [DW-1:0]         slv_wdata,
    output logic [DW/8-1:0]       slv_be,
    input  logic [NUM_SLV*DW-1:0] slv_rdata,
    input  logic [NUM_SLV-1:0]    slv_ack,
    output logic [7:0]            err_cnt,
    output logic [AW-1:0]         err_addr
);
    // the full address is only kept when it is needed for err_addr
`ifdef PERIPH_FABRIC_ERR_LOG_EN
    localparam int CAP_W = AW;
`else
    localparam int CAP_W = AW - SEL_W;
`endif

    typedef enum logic [1:0] {IDLE, BUSY, RESP, GAP} state_t;

    state_t            state_q, state_d;
    logic [NUM_SLV-1:0] cs_q, cs_d;
    logic              wr_q, wr_d;
    logic [CAP_W-1:0]  addr_q, addr_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic [DW/8-1:0]   be_q, be_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [DW-1:0]     data_q, data_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic              ack_q, ack_d;
    logic              rerr_q, rerr_d;
    logic [SEL_W-1:0]  sel;
    logic              sel_ack;
    logic [DW-1:0]     sel_data;

    assign sel = bus.reg_addr[AW-1 -: SEL_W];
    // cs_q is one-hot while BUSY, so masking with it keeps only the selected slave
    assign sel_ack = |(slv_ack & cs_q);

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_SLV; i++)
            if (cs_q[i]) sel_data |= slv_rdata[i*DW +: DW];
    end

    always_comb begin
        state_d = state_q;
        cs_d    = cs_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        data_d  = data_q;
        rdata_d = rdata_q;
        ack_d   = 1'b0;
        rerr_d  = 1'b0;
        case (state_q)
            IDLE: if (bus.reg_cs) begin
                wr_d    = bus.reg_wr;
                addr_d  = bus.reg_addr[CAP_W-1:0];
                wdata_d = bus.reg_wdata;
                be_d    = bus.reg_be;
                cnt_d   = '0;
                err_d   = 32'(sel) >= NUM_SLV;
                cs_d    = err_d ? '0 : NUM_SLV'(1) << sel;
                state_d = err_d ? RESP : BUSY;
            end
            BUSY: if (sel_ack) begin
                data_d  = sel_data;
                cs_d    = '0;
                err_d   = 1'b0;
                state_d = RESP;
            end else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
                cs_d    = '0;
                err_d   = 1'b1;
                state_d = RESP;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            RESP: begin
                ack_d   = 1'b1;
                rerr_d  = err_q;
                rdata_d = err_q ? ERR_DATA : data_q;
                state_d = GAP;
            end
            // GAP lets the master drop its held reg_cs before we look again
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge app_clk) begin
        if (sreset) begin
            state_q <= IDLE;
            cs_q    <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            data_q  <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            rerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cs_q    <= cs_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            data_q  <= data_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            rerr_q  <= rerr_d;
        end
    end

    assign slv_cs        = cs_q;
    assign slv_wr        = wr_q;
    assign slv_addr      = addr_q[AW-SEL_W-1:0];
    assign slv_wdata     = wdata_q;
    assign slv_be        = be_q;
    assign bus.reg_rdata = rdata_q;
    assign bus.reg_ack   = ack_q;
    assign bus.reg_err   = rerr_q;

`ifdef PERIPH_FABRIC_ERR_LOG_EN
    logic [7:0]    err_cnt_q, err_cnt_d;
    logic [AW-1:0] err_addr_q, err_addr_d;

    always_comb begin
        err_cnt_d  = err_cnt_q;
        err_addr_d = err_addr_q;
        if (state_q == RESP && err_q) begin
            err_cnt_d  = err_cnt_q + {7'd0, err_cnt_q != 8'hFF};
            err_addr_d = addr_q;
        end
    end

    always_ff @(posedge app_clk) begin
        if (sreset) begin
            err_cnt_q  <= '0;
            err_addr_q <= '0;
        end else begin
            err_cnt_q  <= err_cnt_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign err_cnt  = err_cnt_q;
    assign err_addr = err_addr_q;
`else
    assign err_cnt  = '0;
    assign err_addr = '0;
`endif
endmodule
